alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Single-button operand and opcode entry front end for the parametrised `alu`. It replaces per-register load buttons with one "enter" button that steps an FSM through A, B and OP capture, then shows a registered result.
- Sits between board switches/buttons and LEDs.
- Adds input synchronisation, edge detection, a clear button, status outputs and a registered result.

Parameters:
- DATA_SIZE, 8, width of operands, switches and result.
- OP_SIZE, 6, opcode width; taken from i_switches[OP_SIZE-1:0]; requires OP_SIZE <= DATA_SIZE.
- DEBOUNCE_CYCLES, 1000000, stable-cycle count required by the debouncer (only used with the optional feature).

Ports:
- i_clk  input  1  system clock, all logic on its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_switches  input  DATA_SIZE  operand/opcode value source.
- i_btn_enter  input  1  asynchronous push button: capture current switch value and advance.
- i_btn_clear  input  1  asynchronous push button: discard entries, return to operand A entry.
- o_result  output  DATA_SIZE  registered ALU result.
- o_result_valid  output  1  high while o_result holds a result for the current A/B/OP.
- o_state  output  2  current FSM state, for LEDs.

Behaviour:
- Input conditioning:
  - Each button passes through a 2-flop synchroniser, then a rising-edge detector.
  - A press yields exactly one 1-cycle pulse, regardless of hold length.
  - Latency from button change to pulse is 3 cycles (2 sync + 1 edge register); the debounce feature adds to this.
- Internal registers data_a, data_b (DATA_SIZE) and operation (OP_SIZE) feed the `alu` instance (DATA_SIZE passed through).
- FSM states and encodings:
  - S_LOAD_A=2'd0, S_LOAD_B=2'd1, S_LOAD_OP=2'd2, S_SHOW=2'd3.
  - o_state equals the state register.
- Transitions and captures on an enter pulse:
  - S_LOAD_A: data_a <= i_switches; go to S_LOAD_B.
  - S_LOAD_B: data_b <= i_switches; go to S_LOAD_OP.
  - S_LOAD_OP: operation <= i_switches[OP_SIZE-1:0]; go to S_SHOW.
  - S_SHOW: data_a <= i_switches; go to S_LOAD_B. This starts a new calculation and clears o_result_valid.
- Result timing:
  - On the cycle after S_SHOW is entered, o_result <= alu output and o_result_valid <= 1. Result latency is 1 cycle after the OP capture edge.
  - o_result holds its value (does not track switches) until the next result capture or reset.
  - o_result_valid is 0 in every state other than S_SHOW once the update completes.
- Clear pulse:
  - Goes to S_LOAD_A and sets o_result_valid <= 0.
  - data_a, data_b, operation and o_result keep their values.
- Priority, same cycle: i_reset > clear pulse > enter pulse.
- Reset values: state=S_LOAD_A; data_a=0, data_b=0, operation=0; o_result=0, o_result_valid=0, o_state=0; synchroniser and edge registers=0.
  - A button held through reset release produces no pulse until it is released and pressed again.
- Reset mid-sequence (any state) abandons partial entries; the first pulse after reset loads A.
- Arithmetic: width, overflow and wrap rules are those of `alu`; the result is truncated to DATA_SIZE bits.
  - Opcodes used here: ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110.

Optional Feature:
- Macro: ALU_SEQ_DEBOUNCE_EN.
- Defined:
  - Each synchronised button feeds a counter debouncer.
  - The debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce resets the counter.
  - The edge detector operates on the debounced level, adding DEBOUNCE_CYCLES cycles of latency.
- Undefined: no debouncer, no counter logic; the DEBOUNCE_CYCLES parameter is ignored; the edge detector operates directly on the synchroniser output.

Test Plan:
- Basic ADD, DATA_SIZE=8: enter presses with switches 8'h05, 8'h03, 8'h20 -> o_state steps 1,2,3; o_result=8'h08 and o_result_valid=1 one cycle after S_SHOW entry.
- SUB wrap: A=8'h02, B=8'h05, OP=6'b100010 -> o_result=8'hFD (wraps); the next enter with switches 8'h10 gives o_state=1 and o_result_valid=0, and o_result still reads 8'hFD.
- Hold/edge: enter held for 50 cycles in S_LOAD_A -> exactly one transition to S_LOAD_B; data_a captured once.
- Clear priority: clear and enter asserted in the same cycle in S_LOAD_OP -> state=S_LOAD_A, operation unchanged, o_result_valid=0.
- Reset mid-operation: i_reset for 1 cycle while in S_LOAD_B with enter held -> all outputs 0, state 0, no pulse until enter is released and re-pressed.
- With ALU_SEQ_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: a 3-cycle enter glitch -> no transition; a 10-cycle press -> one transition, occurring 4 cycles later than in the non-debounced build.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: single-button A / B / OP entry front end for a small ALU.
// One "enter" button walks an FSM through operand A, operand B and opcode
// capture, then shows a registered result; a "clear" button restarts entry.
// Optional build macro: ALU_SEQ_DEBOUNCE_EN adds a counter debouncer per button.
// Contains: alu (combinational datapath), alu_seq_button (sync + edge pulse),
// alu_sequencer (top).

// Combinational ALU; the result wraps to DATA_SIZE bits.
module alu #(
  parameter int DATA_SIZE = 8,
  parameter int OP_SIZE   = 6
) (
  input  logic [DATA_SIZE-1:0] i_a,
  input  logic [DATA_SIZE-1:0] i_b,
  input  logic [OP_SIZE-1:0]   i_op,
  output logic [DATA_SIZE-1:0] o_result
);

  localparam logic [OP_SIZE-1:0] OP_SRL = OP_SIZE'(6'b000010);
  localparam logic [OP_SIZE-1:0] OP_SRA = OP_SIZE'(6'b000011);
  localparam logic [OP_SIZE-1:0] OP_ADD = OP_SIZE'(6'b100000);
  localparam logic [OP_SIZE-1:0] OP_SUB = OP_SIZE'(6'b100010);
  localparam logic [OP_SIZE-1:0] OP_AND = OP_SIZE'(6'b100100);
  localparam logic [OP_SIZE-1:0] OP_OR  = OP_SIZE'(6'b100101);
  localparam logic [OP_SIZE-1:0] OP_XOR = OP_SIZE'(6'b100110);
  localparam logic [OP_SIZE-1:0] OP_NOR = OP_SIZE'(6'b100111);

  // Opcode decode; unknown opcodes produce zero.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    o_result = '0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_SRL:  o_result = i_a >> i_b;
      OP_SRA:  o_result = DATA_SIZE'($signed(i_a) >>> i_b);
      default: o_result = '0;
    endcase
  end

endmodule

// Button conditioning: 2-flop synchroniser, optional debouncer, registered
// rising-edge pulse. A button already held when reset releases is ignored
// until it has been seen released.
module alu_seq_button #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic [1:0] sync;
  logic       level;
  logic       level_q;
  logic       armed;
  logic [1:0] warm_cnt;
  logic       warm_done;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("alu_seq_button: DEBOUNCE_CYCLES must be at least 1");
  end

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, exactly like the hardware it describes.
    if (i_reset) sync <= '0;
    else         sync <= {sync[0], i_btn};
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt;
  logic             db_level;

  // Debouncer: follow the synchronised input only after it has differed from
  // the current level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (sync[1] != db_level) begin
      if (db_cnt == CNT_LAST) begin
        db_level <= sync[1];
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign level = db_level;
`else
  assign level = sync[1];
`endif

  // The synchroniser holds reset zeros for two cycles; only after that does a
  // low level really mean the button is released.
  always_ff @(posedge i_clk) begin
    if (i_reset)                warm_cnt <= '0;
    else if (warm_cnt != 2'd2)  warm_cnt <= warm_cnt + 2'd1;
  end

  assign warm_done = (warm_cnt == 2'd2);

  // Arm once the button is genuinely seen released after reset.
  always_ff @(posedge i_clk) begin
    if (i_reset)                                armed <= 1'b0;
    else if (warm_done && !sync[1] && !level)   armed <= 1'b1;
  end

  // Registered rising-edge detector: one pulse per press.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      level_q <= 1'b0;
      o_pulse <= 1'b0;
    end else begin
      level_q <= level;
      o_pulse <= level & ~level_q & armed;
    end
  end

endmodule

// Top: button conditioning, entry FSM, operand registers and registered result.
module alu_sequencer #(
  parameter int DATA_SIZE       = 8,
  parameter int OP_SIZE         = 6,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DATA_SIZE-1:0] i_switches,
  input  logic                 i_btn_enter,
  input  logic                 i_btn_clear,
  output logic [DATA_SIZE-1:0] o_result,
  output logic                 o_result_valid,
  output logic [1:0]           o_state
);

  typedef enum logic [1:0] {
    S_LOAD_A  = 2'd0,
    S_LOAD_B  = 2'd1,
    S_LOAD_OP = 2'd2,
    S_SHOW    = 2'd3
  } state_t;

  if (OP_SIZE > DATA_SIZE) begin : g_bad_op_size
    $error("alu_sequencer: OP_SIZE must not exceed DATA_SIZE");
  end

  state_t               state;
  state_t               next_state;
  logic                 enter_pulse;
  logic                 clear_pulse;
  logic                 cap_a;
  logic                 cap_b;
  logic                 cap_op;
  logic                 result_pending;
  logic [DATA_SIZE-1:0] data_a;
  logic [DATA_SIZE-1:0] data_b;
  logic [OP_SIZE-1:0]   operation;
  logic [DATA_SIZE-1:0] alu_result;

  alu_seq_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_enter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_enter),
    .o_pulse (enter_pulse)
  );

  alu_seq_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_clear),
    .o_pulse (clear_pulse)
  );

  alu #(.DATA_SIZE(DATA_SIZE), .OP_SIZE(OP_SIZE)) u_alu (
    .i_a      (data_a),
    .i_b      (data_b),
    .i_op     (operation),
    .o_result (alu_result)
  );

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_LOAD_A;
    else         state <= next_state;
  end

  // Next state and capture strobes; clear outranks enter.
  always_comb begin
    next_state = state;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    cap_op     = 1'b0;
    if (clear_pulse) begin
      next_state = S_LOAD_A;
    end else if (enter_pulse) begin
      case (state)
        S_LOAD_A: begin
          cap_a      = 1'b1;
          next_state = S_LOAD_B;
        end
        S_LOAD_B: begin
          cap_b      = 1'b1;
          next_state = S_LOAD_OP;
        end
        S_LOAD_OP: begin
          cap_op     = 1'b1;
          next_state = S_SHOW;
        end
        S_SHOW: begin
          cap_a      = 1'b1;
          next_state = S_LOAD_B;
        end
        default: next_state = S_LOAD_A;
      endcase
    end
  end

  // Operand and opcode capture registers; clear leaves them untouched.
  always_ff @(posedge i_clk) begin
    // NOTE: these are plain registers, not a memory array, so they take a
    // reset value; a true RAM would be left unreset.
    if (i_reset) begin
      data_a    <= '0;
      data_b    <= '0;
      operation <= '0;
    end else begin
      if (cap_a)  data_a    <= i_switches;
      if (cap_b)  data_b    <= i_switches;
      if (cap_op) operation <= i_switches[OP_SIZE-1:0];
    end
  end

  // Result register: loads the ALU output the cycle after S_SHOW is entered
  // and then holds it; validity drops on clear or when a new A is entered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_result       <= '0;
      o_result_valid <= 1'b0;
      result_pending <= 1'b0;
    end else if (clear_pulse) begin
      o_result_valid <= 1'b0;
      result_pending <= 1'b0;
    end else if (cap_a) begin
      o_result_valid <= 1'b0;
      result_pending <= 1'b0;
    end else if (cap_op) begin
      result_pending <= 1'b1;
    end else if (result_pending) begin
      o_result       <= alu_result;
      o_result_valid <= 1'b1;
      result_pending <= 1'b0;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus randomized
// entry sequences against a behavioural model; results are checked by a
// scoreboard monitor decoupled from the stimulus.
module tb_alu_sequencer;

  localparam int DATA_SIZE = 8;
  localparam int OP_SIZE   = 6;
  localparam int DEB       = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int DB = DEB;
`else
  localparam int DB = 0;
`endif
  localparam int HOLD   = 5 + DB;
  localparam int SETTLE = 10 + DB;

  logic                 i_clk;
  logic                 i_reset;
  logic [DATA_SIZE-1:0] i_switches;
  logic                 i_btn_enter;
  logic                 i_btn_clear;
  logic [DATA_SIZE-1:0] o_result;
  logic                 o_result_valid;
  logic [1:0]           o_state;

  alu_sequencer #(
    .DATA_SIZE(DATA_SIZE), .OP_SIZE(OP_SIZE), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_switches     (i_switches),
    .i_btn_enter    (i_btn_enter),
    .i_btn_clear    (i_btn_clear),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .o_state        (o_state)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int tests = 0;
  int fails = 0;

  // Reference model state, expressed as the entry sequence the user sees.
  int         m_state = 0;
  logic [7:0] m_a = 0, m_b = 0, m_last = 0;
  logic [5:0] m_op = 0;
  logic [7:0] exp_q[$];

  logic [5:0] op_list [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    int r;
    case (op)
      6'h20:   r = int'(a) + int'(b);
      6'h22:   r = int'(a) - int'(b) + 256;
      6'h24:   r = int'(a & b);
      6'h25:   r = int'(a | b);
      6'h26:   r = int'(a ^ b);
      default: r = 0;
    endcase
    return 8'(r % 256);
  endfunction

  task automatic wait_neg(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic model_enter(input logic [7:0] sw);
    case (m_state)
      0: begin m_a = sw; m_state = 1; end
      1: begin m_b = sw; m_state = 2; end
      2: begin
        m_op   = sw[5:0];
        m_last = alu_ref(m_a, m_b, m_op);
        exp_q.push_back(m_last);
        m_state = 3;
      end
      default: begin m_a = sw; m_state = 1; end
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_state"}, 32'(o_state), 32'(m_state));
    check({tag, "_valid"}, 32'(o_result_valid), 32'(m_state == 3));
    check({tag, "_result"}, 32'(o_result), 32'(m_last));
  endtask

  task automatic press_enter(input logic [7:0] sw, input int hold);
    i_switches  = sw;
    model_enter(sw);
    i_btn_enter = 1'b1;
    wait_neg(hold);
    i_btn_enter = 1'b0;
    wait_neg(SETTLE);
    check_outputs("enter");
  endtask

  task automatic press_clear();
    i_btn_clear = 1'b1;
    wait_neg(HOLD);
    i_btn_clear = 1'b0;
    wait_neg(SETTLE);
    m_state = 0;
    check_outputs("clear");
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    wait_neg(1);
    i_reset = 1'b0;
    m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_last = 0;
  endtask

  // Scoreboard monitor: a rising o_result_valid must follow a cycle in
  // S_SHOW and carry the oldest expected result.
  logic       prev_valid = 1'b0;
  logic [1:0] prev_state = 2'd0;
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_result_valid && !prev_valid) begin
        check("valid_after_show_entry", 32'(prev_state), 32'd3);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_result: got %0h, expected none", o_result);
        end else begin
          check("scoreboard_result", 32'(o_result), 32'(exp_q.pop_front()));
        end
      end
      if (o_result_valid && o_state != 2'd3) begin
        tests++; fails++;
        $display("FAIL valid_outside_show: state %0d, expected 3", o_state);
      end
    end
    prev_valid = o_result_valid;
    prev_state = o_state;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [1:0] st0;
    logic [7:0] sw;
    i_reset = 1'b1; i_switches = '0; i_btn_enter = 1'b0; i_btn_clear = 1'b0;
    wait_neg(3);
    i_reset = 1'b0;
    wait_neg(5);
    check_outputs("reset");

    // Basic ADD: 5 + 3.
    press_enter(8'h05, HOLD);
    press_enter(8'h03, HOLD);
    press_enter(8'h20, HOLD);
    check("add_result", 32'(o_result), 32'h08);

    // SUB wrap, then a new A keeps the old result but drops validity.
    press_enter(8'h02, HOLD);
    press_enter(8'h05, HOLD);
    press_enter(8'h22, HOLD);
    check("sub_wrap_result", 32'(o_result), 32'hFD);
    press_enter(8'h10, HOLD);
    check("new_a_keeps_result", 32'(o_result), 32'hFD);

    // Long hold produces exactly one transition.
    press_clear();
    press_enter(8'h33, 50);
    press_enter(8'h11, HOLD);
    press_enter(8'h24, HOLD);
    check("hold_and_result", 32'(o_result), 32'h11);

    // Clear and enter together in S_LOAD_OP: clear wins.
    press_clear();
    press_enter(8'h40, HOLD);
    press_enter(8'h41, HOLD);
    i_switches = 8'h26;
    i_btn_enter = 1'b1; i_btn_clear = 1'b1;
    wait_neg(HOLD);
    i_btn_enter = 1'b0; i_btn_clear = 1'b0;
    wait_neg(SETTLE);
    m_state = 0;
    check_outputs("clear_priority");

    // Reset in S_LOAD_B with enter still held.
    i_switches = 8'h44;
    model_enter(8'h44);
    i_btn_enter = 1'b1;
    wait_neg(HOLD + 4);
    check("held_in_load_b", 32'(o_state), 32'd1);
    do_reset();
    check_outputs("mid_reset");
    wait_neg(20 + DB);
    check_outputs("held_after_reset");
    i_btn_enter = 1'b0;
    wait_neg(SETTLE);
    press_enter(8'h07, HOLD);
    press_enter(8'h09, HOLD);
    press_enter(8'h20, HOLD);

    // Press-to-transition latency.
    i_switches = 8'h5A;
    st0 = o_state;
    seen = 0;
    model_enter(8'h5A);
    i_btn_enter = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge i_clk);
      if (n == 10) i_btn_enter = 1'b0;
      if (seen == 0 && o_state != st0) seen = n;
    end
    check("press_latency", 32'(seen), 32'(4 + DB));
    check_outputs("latency_press");

`ifdef ALU_SEQ_DEBOUNCE_EN
    // A glitch shorter than the debounce window is ignored.
    i_btn_enter = 1'b1;
    wait_neg(3);
    i_btn_enter = 1'b0;
    wait_neg(20);
    check_outputs("glitch_ignored");
`endif

    // Randomized entry sequences with occasional clears.
    for (int i = 0; i < 70; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        press_clear();
      end else begin
        sw = 8'($urandom);
        if (m_state == 2) sw = {sw[7:6], op_list[$urandom_range(0, 4)]};
        press_enter(sw, HOLD + int'($urandom_range(0, 6)));
      end
    end

    wait_neg(10);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
